// File: rtl/elevator_controller.sv
// Three-floor elevator controller: latches call requests, travels floor by
// floor, opens the door at requested floors and keeps its travel direction
// while calls remain that way.
module elevator_controller #(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req_in,
    output logic [3:0] floor_code,
    output logic [3:0] dir_code,
    output logic       door_open,
    output logic [2:0] pending,
    output logic       busy
);

    localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);

    localparam logic [3:0] DIR_UP   = 4'd4;
    localparam logic [3:0] DIR_DN   = 4'd8;
    localparam logic [3:0] DIR_NONE = 4'd12;

    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t        state;
    logic [TW-1:0] move_cnt;
    logic [DW-1:0] door_cnt;
    logic          last_valid;
    logic          last_up;

    logic [2:0] eff;
    logic [2:0] cur_bit;
    logic [2:0] door_eff;
    logic [3:0] nxt_floor;
    logic [2:0] nxt_bit;
    logic       can_continue;
    logic       up_avail;
    logic       dn_avail;

    function automatic logic [2:0] floor_bit(input logic [3:0] f);
        case (f)
            4'd1:    floor_bit = 3'b001;
            4'd2:    floor_bit = 3'b010;
            4'd3:    floor_bit = 3'b100;
            default: floor_bit = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] above_mask(input logic [3:0] f);
        case (f)
            4'd1:    above_mask = 3'b110;
            4'd2:    above_mask = 3'b100;
            default: above_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] below_mask(input logic [3:0] f);
        case (f)
            4'd2:    below_mask = 3'b001;
            4'd3:    below_mask = 3'b011;
            default: below_mask = 3'b000;
        endcase
    endfunction

    // Request view and arrival/departure decisions for the current cycle
    always_comb begin
        eff          = pending | req_in;
        cur_bit      = floor_bit(floor_code);
        door_eff     = eff & ~cur_bit;
        nxt_floor    = last_up ? floor_code + 4'd1 : floor_code - 4'd1;
        nxt_bit      = floor_bit(nxt_floor);
        can_continue = last_up ? (nxt_floor != 4'd3) : (nxt_floor != 4'd1);
        up_avail     = |(door_eff & above_mask(floor_code));
        dn_avail     = |(door_eff & below_mask(floor_code));
    end

    // Controller state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            floor_code <= 4'd1;
            dir_code   <= DIR_NONE;
            door_open  <= 1'b0;
            pending    <= 3'b000;
            busy       <= 1'b0;
            move_cnt   <= '0;
            door_cnt   <= '0;
            last_valid <= 1'b0;
            last_up    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|(eff & cur_bit)) begin
                        state      <= DOOR;
                        door_open  <= 1'b1;
                        busy       <= 1'b1;
                        door_cnt   <= DOOR_LOAD;
                        pending    <= door_eff;
                        last_valid <= 1'b0;
                    end else if (|eff) begin
                        state      <= MOVE;
                        busy       <= 1'b1;
                        move_cnt   <= TRAVEL_LOAD;
                        pending    <= eff;
                        last_valid <= 1'b1;
                        // Calls both above and below resolve upward
                        if (|(eff & above_mask(floor_code))) begin
                            last_up  <= 1'b1;
                            dir_code <= DIR_UP;
                        end else begin
                            last_up  <= 1'b0;
                            dir_code <= DIR_DN;
                        end
                    end else begin
                        pending <= eff;
                    end
                end
                MOVE: begin
                    if (move_cnt != '0) begin
                        move_cnt <= move_cnt - TW'(1);
                        pending  <= eff;
                    end else begin
                        floor_code <= nxt_floor;
                        if (|(eff & nxt_bit)) begin
                            state     <= DOOR;
                            door_open <= 1'b1;
                            dir_code  <= DIR_NONE;
                            door_cnt  <= DOOR_LOAD;
                            pending   <= eff & ~nxt_bit;
                        end else if (can_continue) begin
                            move_cnt <= TRAVEL_LOAD;
                            pending  <= eff;
                        end else begin
                            // Unreachable safety net: never run past an end floor
                            state      <= IDLE;
                            busy       <= 1'b0;
                            dir_code   <= DIR_NONE;
                            last_valid <= 1'b0;
                            pending    <= eff;
                        end
                    end
                end
                DOOR: begin
                    // Calls for the floor being served are absorbed
                    pending <= door_eff;
                    if (door_cnt != '0) begin
                        door_cnt <= door_cnt - DW'(1);
                    end else begin
                        door_open <= 1'b0;
                        if (up_avail && (!last_valid || last_up || !dn_avail)) begin
                            state      <= MOVE;
                            move_cnt   <= TRAVEL_LOAD;
                            last_valid <= 1'b1;
                            last_up    <= 1'b1;
                            dir_code   <= DIR_UP;
                        end else if (dn_avail) begin
                            state      <= MOVE;
                            move_cnt   <= TRAVEL_LOAD;
                            last_valid <= 1'b1;
                            last_up    <= 1'b0;
                            dir_code   <= DIR_DN;
                        end else begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            last_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
